// File: rtl/accum_pkg.sv
// -----------------------------------------------------------------------------
// accum_pkg
// Shared definitions for the 4-bit accumulator:
//   OP_W    - operand / result width (4 bits)
//   CNT_W   - operand counter width (holds 0..15)
//   state_t - accumulator FSM states IDLE / ACC / HOLD
// -----------------------------------------------------------------------------
package accum_pkg;

  localparam int OP_W  = 4;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no operand taken yet
    ACC  = 2'd1,  // 1..NUM_OPS-1 operands taken
    HOLD = 2'd2   // result presented, waiting for out_ready
  } state_t;

endpackage

// File: rtl/accum_4bit_if.sv
// -----------------------------------------------------------------------------
// accum_4bit_if
// Operand and result handshake bundle of the accumulator.
//
// Handshake rule (both channels): a beat moves on a rising clock edge where
// valid and ready are both high. The producer holds valid/data stable until
// that edge; ready may be deasserted at any time.
//
//   in_valid  / in_ready  / in_data : operand channel (master -> slave)
//   out_valid / out_ready / sum/ovf : result channel  (slave -> master)
//
// Modports:
//   master - the environment driving operands and consuming results
//   slave  - the accumulator itself
// -----------------------------------------------------------------------------
interface accum_4bit_if;
  import accum_pkg::*;

  logic            in_valid;
  logic            in_ready;
  logic [OP_W-1:0] in_data;
  logic            out_valid;
  logic            out_ready;
  logic [OP_W-1:0] sum;
  logic            ovf;

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, sum, ovf
  );

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, sum, ovf
  );

endinterface

// File: rtl/ripple_adder_4bit.sv
// -----------------------------------------------------------------------------
// ripple_adder_4bit
// Structural 4-bit ripple-carry adder built from a chain of full adders.
//   i_a, i_b : addends (4 bits)
//   i_cin    : carry in
//   o_sum    : 4-bit sum
//   o_cout   : carry out of the top bit
// -----------------------------------------------------------------------------
module ripple_adder_4bit
  import accum_pkg::*;
(
  input  logic [OP_W-1:0] i_a,
  input  logic [OP_W-1:0] i_b,
  input  logic            i_cin,
  output logic [OP_W-1:0] o_sum,
  output logic            o_cout
);

  logic [OP_W:0] w_carry;

  assign w_carry[0] = i_cin;

  for (genvar g = 0; g < OP_W; g++) begin : g_fa
    assign o_sum[g]     = i_a[g] ^ i_b[g] ^ w_carry[g];
    assign w_carry[g+1] = (i_a[g] & i_b[g]) | (w_carry[g] & (i_a[g] ^ i_b[g]));
  end

  assign o_cout = w_carry[OP_W];

endmodule

// File: rtl/accum_4bit.sv
// -----------------------------------------------------------------------------
// accum_4bit
// Sums NUM_OPS unsigned 4-bit operands and presents the result with a
// valid/ready handshake. ovf is sticky for the whole accumulation.
//
// Parameters:
//   NUM_OPS     - operands summed per result (1..15)
// Ports:
//   clk         - clock, rising edge
//   rst_n       - asynchronous active-low reset
//   clear       - synchronous abort, highest priority
//   bus         - accum_4bit_if.slave (operand in, result out)
//   o_dbg_state - current FSM state, for observation only
// Build option:
//   ACCUM_SAT_EN - when defined, a carry-out clamps sum at 15 and it stays
//                  there; otherwise sum wraps modulo 16. ovf is the same in
//                  both builds.
// -----------------------------------------------------------------------------
module accum_4bit
  import accum_pkg::*;
#(
  parameter int NUM_OPS = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           clear,
  accum_4bit_if.slave    bus,
  output state_t         o_dbg_state
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  state_t           r_state;
  logic [OP_W-1:0]  r_sum;
  logic             r_ovf;
  logic [CNT_W-1:0] r_count;
  logic             r_in_ready;
  logic             r_out_valid;

  logic [OP_W-1:0]  w_add_sum;
  logic             w_add_cout;
  logic [OP_W-1:0]  w_sum_next;
  logic             w_xfer;

  ripple_adder_4bit u_adder (
    .i_a    (r_sum),
    .i_b    (bus.in_data),
    .i_cin  (1'b0),
    .o_sum  (w_add_sum),
    .o_cout (w_add_cout)
  );

`ifdef ACCUM_SAT_EN
  // Once the running sum has carried it is pinned at the maximum; adding to
  // 15 either carries again or adds zero, so the clamp holds by itself.
  assign w_sum_next = w_add_cout ? {OP_W{1'b1}} : w_add_sum;
`else
  assign w_sum_next = w_add_sum;
`endif

  // in_ready is registered, so it is already low in HOLD and stays low for
  // the first cycle after reset release.
  assign w_xfer = bus.in_valid && r_in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else if (clear) begin
      r_state     <= IDLE;
      r_sum       <= '0;
      r_ovf       <= 1'b0;
      r_count     <= '0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE, ACC: begin
          r_in_ready <= 1'b1;
          if (w_xfer) begin
            r_sum   <= w_sum_next;
            r_ovf   <= r_ovf | w_add_cout;
            r_count <= r_count + 1'b1;
            if (r_count == LAST_CNT) begin
              r_state     <= HOLD;
              r_in_ready  <= 1'b0;
              r_out_valid <= 1'b1;
            end else begin
              r_state <= ACC;
            end
          end
        end
        HOLD: begin
          if (bus.out_ready) begin
            r_state     <= IDLE;
            r_sum       <= '0;
            r_ovf       <= 1'b0;
            r_count     <= '0;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_sum       <= '0;
          r_ovf       <= 1'b0;
          r_count     <= '0;
          r_in_ready  <= 1'b1;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = r_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.sum       = r_sum;
  assign bus.ovf       = r_ovf;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_accum_4bit.sv
// -----------------------------------------------------------------------------
// tb_accum_4bit
// Self-checking bench for accum_4bit: one instance with NUM_OPS=4 and one
// with NUM_OPS=1. Inputs change 1 time unit after the rising edge; outputs
// are looked at at that same point (well away from the next edge).
// -----------------------------------------------------------------------------
module tb_accum_4bit;
  import accum_pkg::*;

`ifdef ACCUM_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic clear_a;
  logic clear_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  accum_4bit_if a_if ();
  accum_4bit_if b_if ();
  state_t dbg_a;
  state_t dbg_b;

  accum_4bit #(.NUM_OPS(4)) u_dut_a (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_a),
    .bus         (a_if.slave),
    .o_dbg_state (dbg_a)
  );

  accum_4bit #(.NUM_OPS(1)) u_dut_b (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear       (clear_b),
    .bus         (b_if.slave),
    .o_dbg_state (dbg_b)
  );

  // ---------------- scoreboard ----------------
  int n_total = 0;
  int n_bad   = 0;
  logic [4:0] exp_q[$];  // {ovf, sum}

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: the result depends only on the arithmetic total of the batch.
  function automatic logic [4:0] model(input int total);
    logic       o;
    logic [3:0] s;
    o = (total > 15);
    if (SAT) s = (total > 15) ? 4'd15 : 4'(total);
    else     s = 4'(total % 16);
    return {o, s};
  endfunction

  // ---------------- driver tasks (instance A) ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One operand transfer; returns 1 time unit after the transferring edge.
  task automatic push_a(input logic [3:0] d);
    int t;
    t = 0;
    a_if.in_valid = 1'b1;
    a_if.in_data  = d;
    while (!a_if.in_ready && t < 50) begin
      tick();
      t++;
    end
    check("push_ready_timeout", 32'(t >= 50), 32'd0);
    tick();
    a_if.in_valid = 1'b0;
    a_if.in_data  = 4'($urandom_range(0, 15));
  endtask

  // Feed four operands with random idle gaps; ends in HOLD.
  task automatic fill_a(input logic [3:0][3:0] ops, input int max_gap, input string tag);
    for (int i = 0; i < 4; i++) begin
      repeat ($urandom_range(0, max_gap)) begin
        a_if.in_valid = 1'b0;
        a_if.in_data  = 4'($urandom_range(0, 15));
        tick();
      end
      if (i == 3) check({tag, "_ov_before_last"}, 32'(a_if.out_valid), 32'd0);
      push_a(ops[i]);
    end
    check({tag, "_ov_latency"}, 32'(a_if.out_valid), 32'd1);
  endtask

  task automatic pop_a(input string tag);
    a_if.out_ready = 1'b1;
    tick();
    a_if.out_ready = 1'b0;
    check({tag, "_pop_ov"}, 32'(a_if.out_valid), 32'd0);
    check({tag, "_pop_sum"}, 32'(a_if.sum), 32'd0);
    check({tag, "_pop_state"}, 32'(dbg_a), 32'(IDLE));
  endtask

  // ---------------- vector table ----------------
  typedef struct packed {
    logic [3:0][3:0] ops;       // ops[0] is the first operand
    logic [3:0]      sum_wrap;
    logic [3:0]      sum_sat;
    logic            ovf;
  } vec_t;

  vec_t vecs[8];

  function automatic vec_t mk(input int a, input int b, input int c, input int d,
                              input int sw, input int ss, input int o);
    vec_t v;
    v.ops[0] = 4'(a); v.ops[1] = 4'(b); v.ops[2] = 4'(c); v.ops[3] = 4'(d);
    v.sum_wrap = 4'(sw);
    v.sum_sat  = 4'(ss);
    v.ovf      = 1'(o);
    return v;
  endfunction

  // ---------------- watchdog ----------------
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [3:0][3:0] ops;
    logic [4:0]      e;
    int              total;

    vecs[0] = mk( 2,  2,  4,  6, 14, 14, 0);
    vecs[1] = mk(15, 15,  0,  0, 14, 15, 1);
    vecs[2] = mk( 0,  0,  0,  0,  0,  0, 0);
    vecs[3] = mk(15,  0,  0,  0, 15, 15, 0);
    vecs[4] = mk( 8,  8,  0,  0,  0, 15, 1);
    vecs[5] = mk( 1,  2,  3,  4, 10, 10, 0);
    vecs[6] = mk(15,  1, 15,  1,  0, 15, 1);
    vecs[7] = mk( 5,  5,  5,  0, 15, 15, 0);

    rst_n = 1'b0;
    clear_a = 1'b0;
    clear_b = 1'b0;
    a_if.in_valid = 1'b0; a_if.in_data = '0; a_if.out_ready = 1'b0;
    b_if.in_valid = 1'b0; b_if.in_data = '0; b_if.out_ready = 1'b0;

    // Reset state
    repeat (2) tick();
    check("rst_in_ready", 32'(a_if.in_ready), 32'd0);
    check("rst_out_valid", 32'(a_if.out_valid), 32'd0);
    check("rst_sum", 32'(a_if.sum), 32'd0);
    check("rst_ovf", 32'(a_if.ovf), 32'd0);
    check("rst_state", 32'(dbg_a), 32'(IDLE));
    check("rst_b_in_ready", 32'(b_if.in_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    check("rel_in_ready_low", 32'(a_if.in_ready), 32'd0);
    tick();
    check("rel_in_ready_high", 32'(a_if.in_ready), 32'd1);
    check("rel_b_in_ready_high", 32'(b_if.in_ready), 32'd1);

    // Table-driven batches
    for (int i = 0; i < 8; i++) begin
      fill_a(vecs[i].ops, 0, $sformatf("vec%0d", i));
      check($sformatf("vec%0d_sum", i), 32'(a_if.sum),
            32'(SAT ? vecs[i].sum_sat : vecs[i].sum_wrap));
      check($sformatf("vec%0d_ovf", i), 32'(a_if.ovf), 32'(vecs[i].ovf));
      pop_a($sformatf("vec%0d", i));
    end

    // Backpressure: result held five cycles, offered operand refused
    fill_a(vecs[0].ops, 1, "bp");
    a_if.in_valid = 1'b1;
    a_if.in_data  = 4'd7;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_hold_ov", 32'(a_if.out_valid), 32'd1);
      check("bp_hold_sum", 32'(a_if.sum), 32'd14);
      check("bp_hold_ovf", 32'(a_if.ovf), 32'd0);
      check("bp_hold_in_ready", 32'(a_if.in_ready), 32'd0);
    end
    a_if.in_valid = 1'b0;
    pop_a("bp");
    check("bp_in_ready_after", 32'(a_if.in_ready), 32'd1);

    // Clear after two operands, then a fresh batch
    push_a(4'd3);
    push_a(4'd5);
    check("clr_pre_state", 32'(dbg_a), 32'(ACC));
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_state", 32'(dbg_a), 32'(IDLE));
    check("clr_sum", 32'(a_if.sum), 32'd0);
    check("clr_ovf", 32'(a_if.ovf), 32'd0);
    ops[0] = 4'd1; ops[1] = 4'd1; ops[2] = 4'd1; ops[3] = 4'd1;
    fill_a(ops, 0, "clr_next");
    check("clr_next_sum", 32'(a_if.sum), 32'd4);
    check("clr_next_ovf", 32'(a_if.ovf), 32'd0);
    pop_a("clr_next");

    // Clear while holding a result drops it
    fill_a(vecs[5].ops, 0, "clr_hold");
    clear_a = 1'b1;
    tick();
    clear_a = 1'b0;
    check("clr_hold_ov", 32'(a_if.out_valid), 32'd0);
    check("clr_hold_state", 32'(dbg_a), 32'(IDLE));

    // Gaps: in_valid pattern 1,0,0,1,0,1,1 with junk data on idle cycles
    begin
      bit         pat[7];
      logic [3:0] gops[4];
      int         idx;
      pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
      gops = '{4'd1, 4'd2, 4'd3, 4'd4};
      idx = 0;
      for (int i = 0; i < 7; i++) begin
        a_if.in_valid = pat[i];
        a_if.in_data  = pat[i] ? gops[idx] : 4'd15;
        tick();
        if (pat[i]) idx++;
      end
      a_if.in_valid = 1'b0;
      check("gap_ov", 32'(a_if.out_valid), 32'd1);
      check("gap_sum", 32'(a_if.sum), 32'd10);
      check("gap_ovf", 32'(a_if.ovf), 32'd0);
      pop_a("gap");
    end

    // Randomized batches against the reference model
    for (int n = 0; n < 40; n++) begin
      total = 0;
      for (int i = 0; i < 4; i++) begin
        ops[i] = 4'($urandom_range(0, 15));
        total += int'(ops[i]);
      end
      exp_q.push_back(model(total));
      fill_a(ops, 2, "rnd");
      repeat ($urandom_range(0, 3)) tick();
      e = exp_q.pop_front();
      check("rnd_ov", 32'(a_if.out_valid), 32'd1);
      check("rnd_sum", 32'(a_if.sum), 32'(e[3:0]));
      check("rnd_ovf", 32'(a_if.ovf), 32'(e[4]));
      pop_a("rnd");
    end

    // Reset while holding a result
    fill_a(vecs[1].ops, 0, "rsth");
    check("rsth_ov_pre", 32'(a_if.out_valid), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rsth_ov", 32'(a_if.out_valid), 32'd0);
    check("rsth_sum", 32'(a_if.sum), 32'd0);
    check("rsth_ovf", 32'(a_if.ovf), 32'd0);
    check("rsth_in_ready", 32'(a_if.in_ready), 32'd0);
    check("rsth_state", 32'(dbg_a), 32'(IDLE));
    tick();
    rst_n = 1'b1;
    #1;
    check("rsth_rel_in_ready_low", 32'(a_if.in_ready), 32'd0);
    tick();
    check("rsth_rel_in_ready_high", 32'(a_if.in_ready), 32'd1);
    check("rsth_rel_ov", 32'(a_if.out_valid), 32'd0);

    // NUM_OPS = 1: single operand goes straight to HOLD
    for (int n = 0; n < 6; n++) begin
      logic [3:0] d;
      d = (n == 0) ? 4'd9 : 4'($urandom_range(0, 15));
      exp_q.push_back(model(int'(d)));
      check("b_in_ready", 32'(b_if.in_ready), 32'd1);
      b_if.in_valid = 1'b1;
      b_if.in_data  = d;
      tick();
      b_if.in_valid = 1'b0;
      e = exp_q.pop_front();
      check("b_ov", 32'(b_if.out_valid), 32'd1);
      check("b_sum", 32'(b_if.sum), 32'(e[3:0]));
      check("b_ovf", 32'(b_if.ovf), 32'(e[4]));
      check("b_state", 32'(dbg_b), 32'(HOLD));
      check("b_in_ready_hold", 32'(b_if.in_ready), 32'd0);
      b_if.out_ready = 1'b1;
      tick();
      b_if.out_ready = 1'b0;
      check("b_pop_ov", 32'(b_if.out_valid), 32'd0);
      check("b_pop_state", 32'(dbg_b), 32'(IDLE));
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
